// File: rtl/imem_boot_loader_ctrl.sv
// Byte-stream boot loader for the instruction memory: parses a 2-byte length header, writes the payload and stalls the CPU until done.
// Optional trailing 8-bit checksum byte when IMEM_BOOT_CHECKSUM_EN is defined.
module imem_boot_loader_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int MAX_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    input  logic [31:0]       cpu_addr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       byte_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_LOAD   = 3'd3,
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_BYTES);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       byte_count_q, byte_count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              xfer;
    logic [15:0]       new_len;
    logic              unused_cpu_addr_hi;

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    assign rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_LOAD)
`ifdef IMEM_BOOT_CHECKSUM_EN
                   || (state_q == S_CHK)
`endif
                   ;
    assign xfer    = rx_valid && rx_ready;
    assign new_len = {len_q[15:8], rx_data};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_count_d = byte_count_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (boot_start) begin
                    state_d      = S_LEN_HI;
                    byte_count_d = 16'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    sum_d        = 8'd0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = new_len;
                    if ((new_len == 16'd0) || ({1'b0, new_len} > MAX_LEN)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    mem_we_d     = 1'b1;
                    mem_waddr_d  = byte_count_q[ADDR_W-1:0];
                    mem_wdata_d  = rx_data;
                    byte_count_d = byte_count_q + 16'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    sum_d        = sum_q + rx_data;
                    if (byte_count_q == len_q - 16'd1) begin
                        state_d = S_CHK;
                    end
`else
                    if (byte_count_q == len_q - 16'd1) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            // The checksum byte is compared only, never written to memory.
            S_CHK: begin
                if (xfer) begin
                    state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            byte_count_q <= 16'd0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= 8'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_count_q <= byte_count_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign load_done  = (state_q == S_DONE);
    assign load_err   = (state_q == S_ERR);
    assign cpu_hold   = !load_done;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign byte_count = byte_count_q;

    // While the CPU is held the read port is parked at address 0.
    assign mem_raddr          = cpu_hold ? '0 : cpu_addr[ADDR_W-1:0];
    assign unused_cpu_addr_hi = ^cpu_addr[31:ADDR_W];

endmodule

// File: tb/tb_imem_boot_loader_ctrl.sv
// Directed self-checking bench for imem_boot_loader_ctrl; memory writes are logged on the falling edge.
module tb_imem_boot_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [31:0] cpu_addr;
    logic [9:0]  mem_raddr;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] byte_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] log_addr [0:63];
    logic [7:0] log_data [0:63];
    int         wcount = 0;
    int         base;

    imem_boot_loader_ctrl #(.ADDR_W(10), .MAX_BYTES(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_start (boot_start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_addr   (cpu_addr),
        .mem_raddr  (mem_raddr),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wcount < 64) begin
                log_addr[wcount] <= mem_waddr;
                log_data[wcount] <= mem_wdata;
            end
            wcount <= wcount + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [9:0] a, input logic [7:0] d);
        chk({tag, "_addr"}, {22'd0, log_addr[idx]}, {22'd0, a});
        chk({tag, "_data"}, {24'd0, log_data[idx]}, {24'd0, d});
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        rx_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_start();
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; boot_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cpu_addr = 32'h0;

        // T1 reset
        tick(); tick();
        rst = 1'b0;
        chk("t1_cpu_hold",  cpu_hold, 1);
        chk("t1_mem_we",    mem_we, 0);
        chk("t1_load_done", load_done, 0);
        chk("t1_load_err",  load_err, 0);
        chk("t1_rx_ready",  rx_ready, 0);
        chk("t1_mem_raddr", mem_raddr, 0);
        chk("t1_byte_cnt",  byte_count, 0);
        chk("t1_waddr",     mem_waddr, 0);
        chk("t1_wdata",     mem_wdata, 0);
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick(); tick();
        rx_valid = 1'b0;
        chk("t1_idle_ready", rx_ready, 0);
        chk("t1_idle_nowr",  wcount, 0);

        // T2 normal load with rx_valid held high
        base = wcount;
        cpu_addr = 32'h0000_0104;
        pulse_start();
        chk("t2_ready_lenhi", rx_ready, 1);
        chk("t2_raddr_held",  mem_raddr, 0);
        send(8'h00); send(8'h04); send(8'h13);
        chk("t2_we_first",    mem_we, 1);
        chk("t2_waddr_first", mem_waddr, 0);
        chk("t2_wdata_first", mem_wdata, 8'h13);
        chk("t2_bc_first",    byte_count, 1);
        send(8'h00); send(8'h00); send(8'h00);
        rx_valid = 1'b0;
        chk("t2_load_done", load_done, 1);
        chk("t2_cpu_hold",  cpu_hold, 0);
        chk("t2_byte_cnt",  byte_count, 4);
        chk("t2_rx_ready",  rx_ready, 0);
        chk("t2_raddr",     mem_raddr, 10'h104);
        tick();
        chk("t2_we_end",  mem_we, 0);
        chk("t2_nwrites", wcount - base, 4);
        chk_wr("t2_w0", base + 0, 10'd0, 8'h13);
        chk_wr("t2_w1", base + 1, 10'd1, 8'h00);
        chk_wr("t2_w2", base + 2, 10'd2, 8'h00);
        chk_wr("t2_w3", base + 3, 10'd3, 8'h00);
        cpu_addr = 32'h0001_2345;
        #1;
        chk("t2_raddr_trunc", mem_raddr, 10'h345);

        // T3 illegal lengths
        pulse_start();
        chk("t3_restart_done", load_done, 0);
        chk("t3_restart_hold", cpu_hold, 1);
        chk("t3_restart_bc",   byte_count, 0);
        chk("t3_restart_rdy",  rx_ready, 1);
        base = wcount;
        send(8'h04); send(8'h01);
        rx_valid = 1'b0;
        chk("t3_err_1025",  load_err, 1);
        chk("t3_err_hold",  cpu_hold, 1);
        chk("t3_err_ready", rx_ready, 0);
        chk("t3_err_raddr", mem_raddr, 0);
        tick(); tick();
        chk("t3_err_nowr", wcount - base, 0);
        pulse_start();
        chk("t3_err_clear", load_err, 0);
        chk("t3_err_lenhi", rx_ready, 1);
        send(8'h00); send(8'h00);
        rx_valid = 1'b0;
        chk("t3_err_len0", load_err, 1);
        pulse_start();
        send(8'h04); send(8'h00);
        chk("t3_len1024_ok",  load_err, 0);
        chk("t3_len1024_rdy", rx_ready, 1);

        // T5 reset in the middle of the 1024-byte payload
        base = wcount;
        send(8'hAA); send(8'hBB);
        chk("t5_bc_before", byte_count, 2);
        rst = 1'b1; rx_data = 8'hCC;
        tick();
        rst = 1'b0;
        chk("t5_bc",       byte_count, 0);
        chk("t5_hold",     cpu_hold, 1);
        chk("t5_ready",    rx_ready, 0);
        chk("t5_we",       mem_we, 0);
        chk("t5_load_err", load_err, 0);
        repeat (3) tick();
        rx_valid = 1'b0;
        chk("t5_nwrites", wcount - base, 2);
        chk_wr("t5_w0", base + 0, 10'd0, 8'hAA);
        chk_wr("t5_w1", base + 1, 10'd1, 8'hBB);

        // T4 gapped stream with a boot_start pulse mid-LOAD
        cpu_addr = 32'h0000_0104;
        pulse_start();
        base = wcount;
        send_gap(8'h00); send_gap(8'h04);
        send(8'h13);
        rx_valid = 1'b0;
        chk("t4_we_pulse", mem_we, 1);
        tick();
        chk("t4_we_low", mem_we, 0);
        tick();
        pulse_start();
        chk("t4_bc_mid",    byte_count, 1);
        chk("t4_hold_mid",  cpu_hold, 1);
        chk("t4_ready_mid", rx_ready, 1);
        send_gap(8'h00); send_gap(8'h00);
        send(8'h00);
        rx_valid = 1'b0;
        chk("t4_load_done", load_done, 1);
        chk("t4_cpu_hold",  cpu_hold, 0);
        chk("t4_byte_cnt",  byte_count, 4);
        chk("t4_raddr",     mem_raddr, 10'h104);
        tick();
        chk("t4_nwrites", wcount - base, 4);
        chk_wr("t4_w0", base + 0, 10'd0, 8'h13);
        chk_wr("t4_w1", base + 1, 10'd1, 8'h00);
        chk_wr("t4_w2", base + 2, 10'd2, 8'h00);
        chk_wr("t4_w3", base + 3, 10'd3, 8'h00);

        // T7 single-byte program
        pulse_start();
        base = wcount;
        send(8'h00); send(8'h01); send(8'h55);
        rx_valid = 1'b0;
        chk("t7_load_done", load_done, 1);
        chk("t7_byte_cnt",  byte_count, 1);
        tick();
        chk("t7_nwrites", wcount - base, 1);
        chk_wr("t7_w0", base, 10'd0, 8'h55);

`ifdef IMEM_BOOT_CHECKSUM_EN
        // T6 checksum good and bad
        pulse_start();
        base = wcount;
        send(8'h00); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
        rx_valid = 1'b0;
        chk("t6_chk_ready", rx_ready, 1);
        chk("t6_chk_hold",  load_done, 0);
        send(8'h06);
        rx_valid = 1'b0;
        chk("t6_good_done", load_done, 1);
        tick();
        chk("t6_good_nwr", wcount - base, 3);
        pulse_start();
        base = wcount;
        send(8'h00); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h07);
        rx_valid = 1'b0;
        chk("t6_bad_err",  load_err, 1);
        chk("t6_bad_hold", cpu_hold, 1);
        tick();
        chk("t6_bad_nwr", wcount - base, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
